// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - mode presets and segment helpers for the VGA timing generator
package vga_timing_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
    bit          pol;
  } axis_mode_t;

  localparam axis_mode_t VGA640_H  = '{active: 640,  fp: 16, sync: 96,  bp: 48,  pol: 1'b0};
  localparam axis_mode_t VGA640_V  = '{active: 480,  fp: 10, sync: 2,   bp: 33,  pol: 1'b0};
  localparam axis_mode_t SVGA800_H = '{active: 800,  fp: 40, sync: 128, bp: 88,  pol: 1'b1};
  localparam axis_mode_t SVGA800_V = '{active: 600,  fp: 1,  sync: 4,   bp: 23,  pol: 1'b1};
  localparam axis_mode_t XGA1024_H = '{active: 1024, fp: 24, sync: 136, bp: 160, pol: 1'b0};
  localparam axis_mode_t XGA1024_V = '{active: 768,  fp: 3,  sync: 6,   bp: 29,  pol: 1'b0};

  function automatic int unsigned seg_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one timing axis: wrapping counter with registered sync/blank flags
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = 1024,
  parameter int unsigned FP     = 24,
  parameter int unsigned SYNC   = 136,
  parameter int unsigned BP     = 160,
  parameter bit          POL    = 1'b1,
  parameter int unsigned W      = 12
) (
  input  logic         pclk,
  input  logic         rst,
  input  logic         step,
  output logic [W-1:0] count,
  output logic         sync,
  output logic         blnk,
  output logic         wrap
);

  localparam int unsigned  TOTAL    = seg_total(ACTIVE, FP, SYNC, BP);
  localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT      = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_BEG = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_END = W'(ACTIVE + FP + SYNC);

  logic [W-1:0] count_q, count_d;
  logic         sync_q, sync_d;
  logic         blnk_q, blnk_d;

  assign wrap = step && (count_q == LAST);

  // Flags are derived from the next count so they line up with it once registered.
  always_comb begin
    count_d = count_q;
    sync_d  = sync_q;
    blnk_d  = blnk_q;
    if (step) begin
      count_d = wrap ? '0 : count_q + 1'b1;
      blnk_d  = (count_d >= ACT);
      sync_d  = ((count_d >= SYNC_BEG) && (count_d < SYNC_END)) ? POL : ~POL;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      count_q <= '0;
      sync_q  <= ~POL;
      blnk_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      sync_q  <= sync_d;
      blnk_q  <= blnk_d;
    end
  end

  assign count = count_q;
  assign sync  = sync_q;
  assign blnk  = blnk_q;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA timing generator; VGA_TIMING_FRAME_CNT_EN adds frame_cnt
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 1024,
  parameter int unsigned H_FP        = 24,
  parameter int unsigned H_SYNC      = 136,
  parameter int unsigned H_BP        = 160,
  parameter int unsigned V_ACTIVE    = 768,
  parameter int unsigned V_FP        = 3,
  parameter int unsigned V_SYNC      = 6,
  parameter int unsigned V_BP        = 29,
  parameter bit          H_SYNC_POL  = 1'b1,
  parameter bit          V_SYNC_POL  = 1'b1,
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned FRAME_CNT_W = 16
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             ce,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblnk,
  output logic             vblnk,
  output logic             de,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = seg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = seg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_seg
    $fatal(1, "vga_timing_gen: porch and sync widths must be at least 1");
  end
  if ((64'd1 << CNT_W) < 64'(H_TOTAL) || (64'd1 << CNT_W) < 64'(V_TOTAL)) begin : g_bad_cnt_w
    $fatal(1, "vga_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end
  if (FRAME_CNT_W < 1) begin : g_bad_fcnt_w
    $fatal(1, "vga_timing_gen: FRAME_CNT_W must be at least 1");
  end

  logic h_wrap, v_wrap;
  logic line_start_q, frame_start_q;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_SYNC_POL), .W(CNT_W)
  ) u_h_axis (
    .pclk (pclk),
    .rst  (rst),
    .step (ce),
    .count(hcount),
    .sync (hsync),
    .blnk (hblnk),
    .wrap (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_SYNC_POL), .W(CNT_W)
  ) u_v_axis (
    .pclk (pclk),
    .rst  (rst),
    .step (ce && h_wrap),
    .count(vcount),
    .sync (vsync),
    .blnk (vblnk),
    .wrap (v_wrap)
  );

  // v_wrap already implies a horizontal wrap, so it marks the last pixel of the frame.
  always_ff @(posedge pclk) begin
    if (rst) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= h_wrap;
      frame_start_q <= v_wrap;
    end
  end

  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign de          = ~(hblnk | vblnk);

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  always_ff @(posedge pclk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (v_wrap) begin
      frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench for vga_timing_gen (small, negative-polarity and default modes)
module tb_vga_timing_gen;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  logic ce   = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 pclk = ~pclk;

  // p_: small mode positive polarity, n_: small mode negative polarity,
  // d_: default 1024x768, q_: default vertical timing with a 4-pixel line.
  logic [11:0] p_h, p_v, n_h, n_v, d_h, d_v, q_h, q_v;
  logic p_hs, p_vs, p_hb, p_vb, p_de, p_ls, p_fs;
  logic n_hs, n_vs, n_hb, n_vb, n_de, n_ls, n_fs;
  logic d_hs, d_vs, d_hb, d_vb, d_de, d_ls, d_fs;
  logic q_hs, q_vs, q_hb, q_vb, q_de, q_ls, q_fs;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [1:0]  p_fc;
  logic [15:0] n_fc, d_fc, q_fc;
`endif

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CNT_W(12), .FRAME_CNT_W(2)
  ) u_pos (
    .pclk(pclk), .rst(rst), .ce(ce), .hcount(p_h), .vcount(p_v),
    .hsync(p_hs), .vsync(p_vs), .hblnk(p_hb), .vblnk(p_vb), .de(p_de),
    .line_start(p_ls), .frame_start(p_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(p_fc)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .CNT_W(12), .FRAME_CNT_W(16)
  ) u_neg (
    .pclk(pclk), .rst(rst), .ce(ce), .hcount(n_h), .vcount(n_v),
    .hsync(n_hs), .vsync(n_vs), .hblnk(n_hb), .vblnk(n_vb), .de(n_de),
    .line_start(n_ls), .frame_start(n_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(n_fc)
`endif
  );

  vga_timing_gen u_def (
    .pclk(pclk), .rst(rst), .ce(ce), .hcount(d_h), .vcount(d_v),
    .hsync(d_hs), .vsync(d_vs), .hblnk(d_hb), .vblnk(d_vb), .de(d_de),
    .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(d_fc)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(1), .H_FP(1), .H_SYNC(1), .H_BP(1)
  ) u_vdef (
    .pclk(pclk), .rst(rst), .ce(ce), .hcount(q_h), .vcount(q_v),
    .hsync(q_hs), .vsync(q_vs), .hblnk(q_hb), .vblnk(q_vb), .de(q_de),
    .line_start(q_ls), .frame_start(q_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(q_fc)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic adv(inout int h, inout int v, input int ht, input int vt);
    if (h == ht - 1) begin
      h = 0;
      v = (v == vt - 1) ? 0 : v + 1;
    end else begin
      h = h + 1;
    end
  endtask

  // Expected small-mode outputs written straight from the 8/2/2/4 x 4/1/1/2 tables.
  task automatic check_small(input int h, input int v, input bit ls, input bit fs);
    bit hs, vs, hb, vb;
    hs = (h >= 10) && (h <= 11);
    vs = (v == 5);
    hb = (h >= 8);
    vb = (v >= 4);
    check("p_hcount", 32'(p_h), 32'(h));
    check("p_vcount", 32'(p_v), 32'(v));
    check("p_hsync", 32'(p_hs), 32'(hs));
    check("p_vsync", 32'(p_vs), 32'(vs));
    check("p_hblnk", 32'(p_hb), 32'(hb));
    check("p_vblnk", 32'(p_vb), 32'(vb));
    check("p_de", 32'(p_de), 32'(!hb && !vb));
    check("p_line_start", 32'(p_ls), 32'(ls));
    check("p_frame_start", 32'(p_fs), 32'(fs));
    check("n_hsync", 32'(n_hs), 32'(!hs));
    check("n_vsync", 32'(n_vs), 32'(!vs));
  endtask

  initial begin
    int h, v, last_fs, fcnt, n;
    bit adv_now, found;

    // Reset state
    rst = 1'b1;
    ce  = 1'b1;
    tick();
    check_small(0, 0, 1'b0, 1'b0);
    check("d_hsync_rst", 32'(d_hs), 32'd0);
    check("d_de_rst", 32'(d_de), 32'd1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("p_frame_cnt_rst", 32'(p_fc), 32'd0);
`endif

    // Small mode, ce=1: five frames of 128 clocks
    rst = 1'b0;
    h = 0; v = 0; last_fs = 0; fcnt = 0;
    for (int k = 1; k <= 640; k++) begin
      tick();
      adv(h, v, 16, 8);
      check_small(h, v, h == 0, (h == 0) && (v == 0));
      if (p_fs) begin
        check("fs_period_ce1", 32'(k - last_fs), 32'd128);
        last_fs = k;
        fcnt++;
      end
`ifdef VGA_TIMING_FRAME_CNT_EN
      check("p_frame_cnt", 32'(p_fc), 32'(fcnt % 4));
`endif
    end
    check("fs_count_ce1", 32'(fcnt), 32'd5);

    // ce every 3rd clock: two frames of 384 clocks
    rst = 1'b1;
    tick();
    rst = 1'b0;
    h = 0; v = 0; last_fs = 0; fcnt = 0;
    for (int k = 1; k <= 770; k++) begin
      adv_now = (k % 3 == 0);
      ce = adv_now;
      tick();
      if (adv_now) adv(h, v, 16, 8);
      check_small(h, v, adv_now && (h == 0), adv_now && (h == 0) && (v == 0));
      if (p_fs) begin
        check("fs_period_ce3", 32'(k - last_fs), 32'd384);
        last_fs = k;
        fcnt++;
      end
    end
    check("fs_count_ce3", 32'(fcnt), 32'd2);
    ce = 1'b1;

    // Mid-frame reset at hcount=13, vcount=6
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      tick();
      found = (p_h == 12'd13) && (p_v == 12'd6);
    end
    check("reach_13_6", 32'(found), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_small(0, 0, 1'b0, 1'b0);
    n = 0;
    found = 1'b0;
    for (int k = 1; k <= 300 && !found; k++) begin
      tick();
      if (p_fs) begin
        found = 1'b1;
        n = k;
      end
    end
    check("fs_after_midreset", 32'(n), 32'd128);

    // Default mode: one full 1344-pixel line plus a full 806-line vertical cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 3228; k++) begin
      int dh, dv, qh, qv;
      tick();
      dh = k % 1344;
      dv = k / 1344;
      qh = k % 4;
      qv = (k / 4) % 806;
      check("d_hcount", 32'(d_h), 32'(dh));
      check("d_vcount", 32'(d_v), 32'(dv));
      check("d_hblnk", 32'(d_hb), 32'(dh >= 1024));
      check("d_hsync", 32'(d_hs), 32'((dh >= 1048) && (dh <= 1183)));
      check("d_line_start", 32'(d_ls), 32'(dh == 0));
      check("d_vblnk", 32'(d_vb), 32'd0);
      check("q_vcount", 32'(q_v), 32'(qv));
      check("q_vblnk", 32'(q_vb), 32'(qv >= 768));
      check("q_vsync", 32'(q_vs), 32'((qv >= 771) && (qv <= 776)));
      check("q_frame_start", 32'(q_fs), 32'((qh == 0) && (qv == 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA/VESA video timing generator replacing the fixed 1024x768 generator. Produces horizontal/vertical pixel counters, sync and blanking strobes, a data-enable and line/frame start pulses for any mode set by parameters. It supports a pixel clock-enable so one fast clock can drive slower modes. It sits at the head of the display pipeline and feeds the drawing and overlay stages that plot the 13 channel voltages.

## Interface
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, horizontal sync width (pixels)
- H_BP, 160, horizontal back porch (pixels)
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 29, vertical back porch (lines)
- H_SYNC_POL, 1, hsync active level (1 = active-high)
- V_SYNC_POL, 1, vsync active level
- CNT_W, 12, width of hcount/vcount; must hold H_TOTAL-1 and V_TOTAL-1
- FRAME_CNT_W, 16, width of frame_cnt (used only with the macro)
- pclk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- ce  in  1  pixel advance enable; tie high for one pixel per clock
- hcount  out  CNT_W  current pixel column, 0..H_TOTAL-1
- vcount  out  CNT_W  current line, 0..V_TOTAL-1
- hsync, vsync  out  1  sync strobes, at configured polarity
- hblnk, vblnk  out  1  blanking flags, active-high
- de  out  1  data enable = !hblnk && !vblnk
- line_start  out  1  one-clock pulse on the first clock of hcount==0
- frame_start  out  1  one-clock pulse on the first clock of (hcount,vcount)==(0,0)
- frame_cnt  out  FRAME_CNT_W  completed-frame count (only with the macro)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is defined the same way from the V_ parameters.
- All outputs are registered. Every flag is aligned to the hcount/vcount values presented in the same cycle.
- The position advances only on clocks with ce=1. With ce=0, every output holds, except that the pulses go to 0.
- Horizontal: hcount == H_TOTAL-1 with ce wraps hcount to 0. Otherwise hcount increments.
- Vertical: vcount changes only on a horizontal wrap. At V_TOTAL-1 it wraps to 0; otherwise it increments.
- hblnk = (hcount >= H_ACTIVE).
- vblnk = (vcount >= V_ACTIVE).
- hsync is active when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.
- vsync is active when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC. vsync changes only at line boundaries, coincident with hcount==0.
- line_start and frame_start are 1 only on the clock where the counter wrap that produces hcount==0 (or (0,0)) is registered.
- A simultaneous horizontal and vertical wrap (last pixel of frame) asserts both line_start and frame_start in the same clock.
- Reset, including mid-frame:
  - hcount=0, vcount=0.
  - hblnk=vblnk=0, de=1.
  - hsync=!H_SYNC_POL, vsync=!V_SYNC_POL.
  - line_start=frame_start=0, frame_cnt=0.
- The first frame after reset therefore starts without a frame_start pulse. The first frame_start pulse comes at the first wrap.
- rst overrides ce.

## Timing
- Latency from a ce=1 clock to the updated outputs is 1 clock.
- Counters use no saturation; they only wrap modulo H_TOTAL/V_TOTAL.
- The default mode with ce=1 at 65 MHz gives 1344x806 clocks per frame.
- Parameter sanity is checked at elaboration; a violation is a fatal error:
  - all porch/sync widths >= 1;
  - 2^CNT_W >= max(H_TOTAL, V_TOTAL).

## Configuration
- VGA_TIMING_FRAME_CNT_EN defined:
  - frame_cnt port exists.
  - It increments modulo 2^FRAME_CNT_W in the same clock as frame_start.
  - It is reset to 0.
- Macro undefined: the frame_cnt port and its register are absent. All other behaviour is identical.

## Structure
- Package vga_timing_pkg holds:
  - the mode preset constants (H/V active, porch and sync values, polarities) for 640x480@60, 800x600@60 and 1024x768@60;
  - a function computing the total from the four segment widths.
- Sub-module vga_axis_counter (parameters ACTIVE, FP, SYNC, BP, POL, W; inputs pclk, rst, step; outputs count, sync, blnk, wrap) is instantiated twice:
  - horizontal instance: step = ce;
  - vertical instance: step = ce && horizontal wrap.

## Test plan
- Small mode H=8/2/2/4, V=4/1/1/2, ce=1, positive polarity:
  - hcount runs 0..15;
  - hsync is high at hcount 10..11;
  - hblnk is high at hcount 8..15;
  - vsync is high for all of vcount 5;
  - frame_start pulses every 128 clocks.
- Same mode with ce pulsing every 3rd clock:
  - each hcount value holds 3 clocks;
  - frame_start is high for exactly 1 clock per frame, 384 clocks apart.
- Negative polarity (H_SYNC_POL=0, V_SYNC_POL=0):
  - hsync idles 1 and is 0 at hcount 10..11;
  - after rst, hsync=vsync=1.
- Assert rst at hcount=13, vcount=6:
  - next clock shows hcount=0, vcount=0, de=1, no frame_start;
  - first frame_start pulse comes 128 clocks later.
- Default 1024x768 mode:
  - hblnk rises at hcount 1024;
  - hsync spans 1048..1183;
  - vblnk rises at vcount 768;
  - vsync spans 771..776;
  - 1344*806 clocks per frame.
- VGA_TIMING_FRAME_CNT_EN defined, FRAME_CNT_W=2, small mode: frame_cnt steps 0,1,2,3,0 at successive frame_start pulses.
